// File: rtl/ntt_addr_pkg.sv
// Shared types and pure helpers for the NTT address sequencer: FSM states,
// per-stage beat count, bit insertion and twiddle exponent derivation.
package ntt_addr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int beats_per_stage(input int logn, input int nbfu);
    return (1 << logn) / (2 * nbfu);
  endfunction

  // Inserts bit_val at position pos, shifting bits at and above pos up by one.
  function automatic logic [31:0] insert_bit(input logic [31:0] value, input int pos,
                                             input logic bit_val);
    logic [31:0] low_mask;
    low_mask = (32'd1 << pos) - 32'd1;
    return ((value & ~low_mask) << 1) | ({31'd0, bit_val} << pos) | (value & low_mask);
  endfunction

  function automatic logic [31:0] tw_exp(input logic [31:0] b, input int s, input int logn);
    logic [31:0] low_mask;
    logic [31:0] width_mask;
    low_mask   = (32'd1 << s) - 32'd1;
    width_mask = (32'd1 << (logn - 1)) - 32'd1;
    return ((b & low_mask) << (logn - 1 - s)) & width_mask;
  endfunction

endpackage

// File: rtl/ntt_addr_lane.sv
// Combinational decode of one butterfly index and stage into its coefficient
// pair addresses and twiddle exponent.
module ntt_addr_lane
  import ntt_addr_pkg::*;
#(
  parameter int LOGN = 10,
  parameter int SW   = 4
) (
  input  logic [LOGN-2:0] b,
  input  logic [SW-1:0]   s,
  output logic [LOGN-1:0] addr_lo,
  output logic [LOGN-1:0] addr_hi,
  output logic [LOGN-2:0] tw_idx
);

  always_comb begin
    addr_lo = LOGN'(insert_bit(32'(b), int'(s), 1'b0));
    addr_hi = LOGN'(insert_bit(32'(b), int'(s), 1'b1));
    tw_idx  = (LOGN-1)'(tw_exp(32'(b), int'(s), LOGN));
  end

endmodule

// File: rtl/ntt_addr_sequencer.sv
// Self-running stage/butterfly counter for a radix-2 NTT: issues NBFU
// butterfly address pairs per beat with backpressure and inter-stage gaps.
module ntt_addr_sequencer
  import ntt_addr_pkg::*;
#(
  parameter int LOGN      = 10,
  parameter int NBFU      = 2,
  parameter int STAGE_GAP = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       inverse,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [NBFU*LOGN-1:0]       addr_lo,
  output logic [NBFU*LOGN-1:0]       addr_hi,
  output logic [NBFU*(LOGN-1)-1:0]   tw_idx,
  output logic [$clog2(LOGN)-1:0]    stage,
  output logic                       last,
  output logic                       busy,
  output logic                       done
);

  localparam int SW    = $clog2(LOGN);
  localparam int BEATS = beats_per_stage(LOGN, NBFU);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GW    = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(BEATS - 1);
  localparam logic [SW-1:0] STAGE_MAX = SW'(LOGN - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] s_q, s_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          inv_q, inv_d;
  logic          done_q, done_d;

  logic          fire;
  logic          cnt_end;
  logic          final_stage;
  logic [SW-1:0] next_stage;

  assign fire        = (state_q == RUN) && out_ready;
  assign cnt_end     = (cnt_q == CNT_LAST);
  assign final_stage = (s_q == (inv_q ? '0 : STAGE_MAX));
  assign next_stage  = inv_q ? (s_q - SW'(1)) : (s_q + SW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      gap_q   <= '0;
      inv_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      gap_q   <= gap_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    gap_d   = gap_q;
    inv_d   = inv_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          gap_d   = '0;
          inv_d   = inverse;
          s_d     = inverse ? STAGE_MAX : '0;
        end
      end
      RUN: begin
        if (fire) begin
          if (cnt_end) begin
            cnt_d = '0;
            if (final_stage) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              s_d     = next_stage;
              gap_d   = '0;
              state_d = (STAGE_GAP == 0) ? RUN : GAP;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = RUN;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Buses are forced to zero outside RUN so idle/gap cycles present a clean bus.
  assign out_valid = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign stage     = busy ? s_q : '0;
  assign last      = out_valid && final_stage && cnt_end;

  for (genvar j = 0; j < NBFU; j++) begin : g_lane
    logic [LOGN-2:0] b;
    logic [LOGN-1:0] lo;
    logic [LOGN-1:0] hi;
    logic [LOGN-2:0] tw;

    assign b = (LOGN-1)'(int'(cnt_q) * NBFU + j);

    ntt_addr_lane #(
      .LOGN (LOGN),
      .SW   (SW)
    ) u_lane (
      .b       (b),
      .s       (s_q),
      .addr_lo (lo),
      .addr_hi (hi),
      .tw_idx  (tw)
    );

    assign addr_lo[j*LOGN +: LOGN]         = out_valid ? lo : '0;
    assign addr_hi[j*LOGN +: LOGN]         = out_valid ? hi : '0;
    assign tw_idx[j*(LOGN-1) +: (LOGN-1)] = out_valid ? tw : '0;
  end

endmodule
